// File: rtl/rs_alu_scheduler.sv
// Scheduler for a bank of ALU reservation-station lines sharing one non-pipelined ALU:
// line allocation, round-robin ALU dispatch, ALU_LAT hold and CDB write-back handshake.
module rs_alu_scheduler #(
    parameter int          N_LINES  = 4,
    parameter int          ALU_LAT  = 2,
    parameter logic [7:0]  TAG_BASE = 8'h01,
    localparam int         SEL_W    = $clog2(N_LINES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               alloc_req,
    output logic               alloc_ack,
    output logic [N_LINES-1:0] issue,
    output logic [7:0]         alloc_tag,
    output logic               full,
    input  logic [N_LINES-1:0] line_busy,
    input  logic [N_LINES-1:0] line_ready,
    output logic [SEL_W-1:0]   alu_sel,
    output logic               alu_active,
    output logic               cdb_req,
    output logic [7:0]         cdb_req_tag,
    input  logic               cdb_gnt,
    output logic [N_LINES-1:0] FU_result_taken
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        WB
    } state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [N_LINES-1:0] mask_q, mask_d;

    logic [SEL_W-1:0]     free_idx;
    logic [N_LINES-1:0]   cand;
    logic [2*N_LINES-1:0] cand_rot2;
    logic [N_LINES-1:0]   cand_rot;
    logic [SEL_W:0]       pick_off;
    logic [SEL_W-1:0]     pick_idx;
    logic [N_LINES-1:0]   sel_onehot;

    // (a + b) mod N_LINES for a < N_LINES, b <= N_LINES; one extra bit covers the overflow.
    function automatic logic [SEL_W-1:0] wrap_add(input logic [SEL_W-1:0] a,
                                                   input logic [SEL_W:0]   b);
        logic [SEL_W:0] s;
        s = {1'b0, a} + b;
        if (s >= (SEL_W+1)'(N_LINES))
            s = s - (SEL_W+1)'(N_LINES);
        return s[SEL_W-1:0];
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        free_idx = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (!line_busy[i])
                free_idx = SEL_W'(i);
        end
        full      = &line_busy;
        alloc_ack = rst & alloc_req & ~full;
        issue     = alloc_ack ? (N_LINES'(1) << free_idx) : '0;
        alloc_tag = TAG_BASE + 8'(free_idx);
    end

    // Rotating the doubled candidate vector puts rr_ptr at bit 0, so lowest-set-bit is round-robin.
    always_comb begin
        cand      = line_ready & line_busy & ~mask_q;
        cand_rot2 = {cand, cand} >> rr_ptr_q;
        cand_rot  = cand_rot2[N_LINES-1:0];
        pick_off  = '0;
        for (int i = N_LINES - 1; i >= 0; i--) begin
            if (cand_rot[i])
                pick_off = (SEL_W+1)'(i);
        end
        pick_idx = wrap_add(rr_ptr_q, pick_off);
    end

    assign sel_onehot = N_LINES'(1) << sel_q;

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        mask_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (|cand) begin
                    sel_d    = pick_idx;
                    cnt_d    = 4'(ALU_LAT - 1);
                    rr_ptr_d = wrap_add(pick_idx, (SEL_W+1)'(1));
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == '0)
                    state_d = WB;
                else
                    cnt_d = cnt_q - 4'd1;
            end
            WB: begin
                // Mask the freed line for one arbitration: its data_ready is still stale.
                if (cdb_gnt) begin
                    mask_d  = sel_onehot;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            mask_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
        end
    end

    assign alu_sel         = sel_q;
    assign alu_active      = (state_q == EXEC);
    assign cdb_req         = (state_q == WB);
    assign cdb_req_tag     = TAG_BASE + 8'(sel_q);
    assign FU_result_taken = (state_q == WB && cdb_gnt) ? sel_onehot : '0;

endmodule

// File: tb/tb_rs_alu_scheduler.sv
// Directed bench for rs_alu_scheduler (N_LINES=4, ALU_LAT=2, TAG_BASE=1) with a
// FU_result_taken scoreboard fed by the stimulus and drained by a monitor.
module tb_rs_alu_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       alloc_req;
    logic       alloc_ack;
    logic [3:0] issue;
    logic [7:0] alloc_tag;
    logic       full;
    logic [3:0] line_busy;
    logic [3:0] line_ready;
    logic [1:0] alu_sel;
    logic       alu_active;
    logic       cdb_req;
    logic [7:0] cdb_req_tag;
    logic       cdb_gnt;
    logic [3:0] FU_result_taken;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    rs_alu_scheduler #(
        .N_LINES (4),
        .ALU_LAT (2),
        .TAG_BASE(8'h01)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .alloc_req      (alloc_req),
        .alloc_ack      (alloc_ack),
        .issue          (issue),
        .alloc_tag      (alloc_tag),
        .full           (full),
        .line_busy      (line_busy),
        .line_ready     (line_ready),
        .alu_sel        (alu_sel),
        .alu_active     (alu_active),
        .cdb_req        (cdb_req),
        .cdb_req_tag    (cdb_req_tag),
        .cdb_gnt        (cdb_gnt),
        .FU_result_taken(FU_result_taken)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every FU_result_taken pulse must match the next expected line.
    always @(negedge clk) begin
        if (rst && FU_result_taken != 4'b0000) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL fu_unexpected: got %0h expected no pulse (t=%0t)",
                         FU_result_taken, $time);
            end else begin
                int exp_line;
                exp_line = exp_q.pop_front();
                check("fu_onehot", 32'(FU_result_taken), 32'(1) << exp_line);
                check("fu_cdb_tag", 32'(cdb_req_tag), 32'(exp_line + 1));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b0;
        alloc_req  = 1'b1;
        line_busy  = 4'b0000;
        line_ready = 4'b0000;
        cdb_gnt    = 1'b0;

        // Reset state, with an allocation request present
        @(negedge clk);
        check("rst_alloc_ack", 32'(alloc_ack), 0);
        check("rst_issue", 32'(issue), 0);
        check("rst_alu_sel", 32'(alu_sel), 0);
        check("rst_alu_active", 32'(alu_active), 0);
        check("rst_cdb_req", 32'(cdb_req), 0);
        check("rst_cdb_tag", 32'(cdb_req_tag), 32'h01);
        check("rst_fu", 32'(FU_result_taken), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Allocation
        line_busy = 4'b0101;
        @(negedge clk);
        check("alloc_issue_0101", 32'(issue), 32'b0010);
        check("alloc_tag_0101", 32'(alloc_tag), 32'h02);
        check("alloc_ack_0101", 32'(alloc_ack), 1);
        check("alloc_full_0101", 32'(full), 0);
        next_cycle();
        line_busy = 4'b1111;
        @(negedge clk);
        check("alloc_full_1111", 32'(full), 1);
        check("alloc_ack_1111", 32'(alloc_ack), 0);
        check("alloc_issue_1111", 32'(issue), 0);
        next_cycle();
        line_busy = 4'b0000;
        @(negedge clk);
        check("alloc_issue_0000", 32'(issue), 32'b0001);
        check("alloc_tag_0000", 32'(alloc_tag), 32'h01);
        next_cycle();
        line_busy = 4'b0111;
        @(negedge clk);
        check("alloc_issue_0111", 32'(issue), 32'b1000);
        check("alloc_tag_0111", 32'(alloc_tag), 32'h04);
        next_cycle();
        alloc_req = 1'b0;
        line_busy = 4'b0000;
        @(negedge clk);
        check("alloc_noreq_ack", 32'(alloc_ack), 0);
        check("alloc_noreq_issue", 32'(issue), 0);

        // Single op on line 2
        next_cycle();
        line_busy  = 4'b0100;
        line_ready = 4'b0100;
        exp_q.push_back(2);
        @(negedge clk);
        check("op_c0_active", 32'(alu_active), 0);
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            @(negedge clk);
            check("op_exec_active", 32'(alu_active), 1);
            check("op_exec_sel", 32'(alu_sel), 2);
            check("op_exec_cdb_req", 32'(cdb_req), 0);
        end
        for (int c = 3; c <= 4; c++) begin
            next_cycle();
            @(negedge clk);
            check("op_wb_cdb_req", 32'(cdb_req), 1);
            check("op_wb_tag", 32'(cdb_req_tag), 32'h03);
            check("op_wb_active", 32'(alu_active), 0);
            check("op_wb_fu", 32'(FU_result_taken), 0);
        end
        next_cycle();
        cdb_gnt = 1'b1;
        @(negedge clk);
        check("op_gnt_fu", 32'(FU_result_taken), 32'b0100);
        next_cycle();
        cdb_gnt    = 1'b0;
        line_busy  = 4'b0000;
        line_ready = 4'b0000;
        @(negedge clk);
        check("op_idle_cdb_req", 32'(cdb_req), 0);
        check("op_idle_active", 32'(alu_active), 0);
        check("op_idle_fu", 32'(FU_result_taken), 0);

        // CDB backpressure: rr_ptr is now 3, lines 1 and 3 ready, line 3 wins
        next_cycle();
        line_busy  = 4'b1010;
        line_ready = 4'b1010;
        exp_q.push_back(3);
        @(negedge clk);
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            @(negedge clk);
            check("bp_exec_active", 32'(alu_active), 1);
            check("bp_exec_sel", 32'(alu_sel), 3);
        end
        for (int c = 3; c <= 12; c++) begin
            next_cycle();
            @(negedge clk);
            check("bp_wb_cdb_req", 32'(cdb_req), 1);
            check("bp_wb_tag", 32'(cdb_req_tag), 32'h04);
            check("bp_wb_fu", 32'(FU_result_taken), 0);
            check("bp_wb_no_dispatch", 32'(alu_active), 0);
        end
        next_cycle();
        cdb_gnt = 1'b1;
        @(negedge clk);
        check("bp_gnt_fu", 32'(FU_result_taken), 32'b1000);

        // Stale-ready masking on line 1
        next_cycle();
        cdb_gnt    = 1'b0;
        line_busy  = 4'b0010;
        line_ready = 4'b0010;
        exp_q.push_back(1);
        @(negedge clk);
        check("mask_idle_active", 32'(alu_active), 0);
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            @(negedge clk);
            check("mask_exec_active", 32'(alu_active), 1);
            check("mask_exec_sel", 32'(alu_sel), 1);
        end
        next_cycle();
        cdb_gnt = 1'b1;
        @(negedge clk);
        check("mask_gnt_fu", 32'(FU_result_taken), 32'b0010);
        next_cycle();
        cdb_gnt = 1'b0;
        @(negedge clk);
        check("mask_stale_idle", 32'(alu_active), 0);
        next_cycle();
        line_busy  = 4'b0000;
        line_ready = 4'b0000;
        @(negedge clk);
        check("mask_no_reselect", 32'(alu_active), 0);

        // Reset in EXEC: rr_ptr is now 2, dispatch line 2 then reset mid-op
        next_cycle();
        line_busy  = 4'b0100;
        line_ready = 4'b0100;
        @(negedge clk);
        next_cycle();
        @(negedge clk);
        check("rexec_active_before", 32'(alu_active), 1);
        #2 rst = 1'b0;
        cdb_gnt    = 1'b1;
        line_busy  = 4'b0000;
        line_ready = 4'b0000;
        #1;
        check("rexec_active", 32'(alu_active), 0);
        check("rexec_cdb_req", 32'(cdb_req), 0);
        check("rexec_fu", 32'(FU_result_taken), 0);
        check("rexec_sel", 32'(alu_sel), 0);
        repeat (2) @(posedge clk);

        // Round-robin after reset: all ready, grant tied high -> 0,1,2,3,0 every 4 cycles
        #1 rst = 1'b1;
        line_busy  = 4'b1111;
        line_ready = 4'b1111;
        for (int k = 0; k < 5; k++)
            exp_q.push_back(k % 4);
        @(negedge clk);
        for (int c = 1; c <= 21; c++) begin
            next_cycle();
            if (c == 18)
                line_ready = 4'b0000;
            @(negedge clk);
            if ((c % 4) == 1 && c <= 17) begin
                check("rr_start_active", 32'(alu_active), 1);
                check("rr_start_sel", 32'(alu_sel), 32'((c / 4) % 4));
            end
            if ((c % 4) == 0 || c == 21)
                check("rr_gap_active", 32'(alu_active), 0);
            if ((c % 4) == 2)
                check("rr_exec_no_fu", 32'(FU_result_taken), 0);
        end
        cdb_gnt   = 1'b0;
        line_busy = 4'b0000;
        repeat (3) next_cycle();
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rs_alu_scheduler.md
Name: rs_alu_scheduler

Overview:
- Controls a bank of N ALU reservation-station lines that share one non-pipelined ALU.
- Allocates free lines to incoming issued instructions and generates each line's issue strobe and tag.
- Arbitrates round-robin among operand-ready lines for the ALU, and holds the chosen line for ALU_LAT cycles.
- Requests the CDB, then pulses that line's FU_result_taken when the CDB grant arrives.

Parameters:
- N_LINES, 4: number of RS ALU lines managed (2..8).
- ALU_LAT, 2: ALU execution cycles per operation (1..15).
- TAG_BASE, 8'h01: tag of line 0; line k has tag TAG_BASE+k. Tag 8'h00 is reserved for "no dependency".

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- alloc_req  input  1  decoder has an ALU-class instruction to issue this cycle.
- alloc_ack  output  1  combinational; a line was allocated this cycle.
- issue  output  N_LINES  one-hot issue strobes to the lines; all zero when alloc_ack=0.
- alloc_tag  output  8  tag of the allocated line, for the register-status table.
- full  output  1  all lines busy.
- line_busy  input  N_LINES  busy outputs of the lines.
- line_ready  input  N_LINES  data_ready outputs of the lines.
- alu_sel  output  clog2(N_LINES)  index of the line whose v1/v2/ALUControl drive the ALU mux.
- alu_active  output  1  ALU is executing for alu_sel.
- cdb_req  output  1  request the CDB to broadcast the ALU result.
- cdb_req_tag  output  8  tag accompanying cdb_req (TAG_BASE+alu_sel).
- cdb_gnt  input  1  CDB arbiter grants the request this cycle.
- FU_result_taken  output  N_LINES  one-hot, one-cycle pulse freeing the line.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, rr_ptr=0, cnt=0, mask=0.
  - Outputs at reset: alu_sel=0, alu_active=0, cdb_req=0, cdb_req_tag=TAG_BASE, FU_result_taken=0.
  - issue is forced 0 and alloc_ack=0 while rst=0.
- Allocation (combinational):
  - Selects the lowest-index line with line_busy=0.
  - alloc_ack = alloc_req & ~full.
  - issue has exactly that one bit set; alloc_tag = TAG_BASE + index.
  - full = &line_busy; alloc_req while full gives alloc_ack=0 and issue=0. The decoder stalls.
- FSM states: IDLE, EXEC, WB.
  - IDLE:
    - Candidates = line_ready & line_busy & ~mask.
    - Round-robin select: the first candidate at or after rr_ptr, wrapping modulo N_LINES.
    - If any candidate: register alu_sel, cnt=ALU_LAT-1, rr_ptr=(sel+1) mod N_LINES, go to EXEC.
  - EXEC:
    - alu_active=1.
    - If cnt==0, go to WB; otherwise cnt decrements.
    - ALU_LAT=1 therefore spends exactly one cycle in EXEC.
  - WB:
    - cdb_req=1 and cdb_req_tag held stable until cdb_gnt.
    - When cdb_gnt=1 in WB, FU_result_taken[alu_sel] is 1 in that same cycle (combinational on cdb_gnt). The ALU result stays valid, since the line holds its operands until then.
    - Go to IDLE.
- mask:
  - Set to the one-hot of the freed line on the grant edge; cleared on the next edge.
  - This keeps the stale data_ready of a line being freed out of the next arbitration.
- Latency:
  - Ready line to alu_active: 1 cycle.
  - alu_active duration: ALU_LAT cycles.
  - cdb_req asserts the cycle after EXEC ends.
  - Minimum start-to-start spacing: ALU_LAT+2 cycles.
- Simultaneous events:
  - Allocation is independent of the FSM.
  - A line freed by FU_result_taken in cycle t reads busy=1 in t, so it is not reallocated before t+1.
  - A line issued in t is not a dispatch candidate before t+1.
- cdb_gnt asserted outside WB is ignored.
- Reset mid-operation: the FSM returns to IDLE and no FU_result_taken pulse is generated. The lines are reset by the same reset.

Test Plan:
- Reset and allocation: hold rst=0 for 3 cycles, then release. Drive alloc_req=1 with line_busy=4'b0101, N=4, TAG_BASE=1 -> issue=4'b0010, alloc_tag=8'h02, alloc_ack=1. With line_busy=4'b1111 -> full=1, alloc_ack=0, issue=0.
- Single op, ALU_LAT=2: line_ready=line_busy=4'b0100 at cycle 0 -> alu_sel=2 and alu_active=1 in cycles 1-2. cdb_req=1 with cdb_req_tag=8'h03 from cycle 3. cdb_gnt at cycle 5 -> FU_result_taken=4'b0100 in cycle 5 only; state IDLE at cycle 6.
- Round-robin fairness: all four lines ready continuously, cdb_gnt tied 1 -> grant order 0,1,2,3,0. Each start is spaced ALU_LAT+2=4 cycles.
- Stale-ready masking: keep line_ready[1]=1 for one cycle after its FU_result_taken pulse -> line 1 is not reselected in that cycle.
- CDB backpressure: hold cdb_gnt=0 for 10 cycles in WB -> cdb_req and cdb_req_tag are stable, no FU_result_taken, and no new dispatch despite other ready lines.
- Reset in EXEC: assert rst=0 mid-EXEC -> alu_active, cdb_req and FU_result_taken go to 0 immediately. After release, rr_ptr=0 and line 0 is selected first.
